// File: rtl/data_cache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package data_cache_pkg;

  localparam int unsigned LINES_DEFAULT = 16;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned DATA_W        = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } cache_state_e;

endpackage

// File: rtl/data_cache_line_array.sv
// Line storage: valid/tag/data per line, async read by index, one sync write port.
module data_cache_line_array
  import data_cache_pkg::*;
#(
  parameter int unsigned LINES      = LINES_DEFAULT,
  parameter int unsigned INDEX_BITS = $clog2(LINES_DEFAULT),
  parameter int unsigned TAG_BITS   = ADDR_W - $clog2(LINES_DEFAULT) - 2
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  output logic                  o_rd_valid,
  output logic [TAG_BITS-1:0]   o_rd_tag,
  output logic [DATA_W-1:0]     o_rd_data,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic [TAG_BITS-1:0]   i_wr_tag,
  input  logic [DATA_W-1:0]     i_wr_data
);

  logic [LINES-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [DATA_W-1:0]   r_data [LINES];

  // Valid bits: cleared by reset, set on any line write.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data are only meaningful behind a valid bit, so they are not reset.
  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through L1 data cache with blocking memory handshake.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned LINES = LINES_DEFAULT
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic [ADDR_W-1:0] i_cache_address,
  input  logic              i_cache_read,
  input  logic              i_cache_write,
  inout  wire  [DATA_W-1:0] io_cache_data,
  output logic              o_cache_hit,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [DATA_W-1:0] o_mem_write_data,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_mem_ready
);

  localparam int unsigned INDEX_BITS = $clog2(LINES);
  localparam int unsigned TAG_BITS   = ADDR_W - INDEX_BITS - 2;

  cache_state_e r_state;
  cache_state_e w_next;

  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [INDEX_BITS-1:0] w_cmp_index;
  logic [TAG_BITS-1:0]   w_cmp_tag;
  logic                  w_rd_valid;
  logic [TAG_BITS-1:0]   w_rd_tag;
  logic [DATA_W-1:0]     w_rd_data;
  logic                  w_line_hit;
  logic                  w_cap_addr;
  logic                  w_cap_data;
  logic                  w_wr_en;
  logic [DATA_W-1:0]     w_wr_data;
  logic                  w_drive;
  logic                  w_unused_addr_lsb;

  // Byte offset within the word is irrelevant to a word-granular cache.
  assign w_unused_addr_lsb = ^i_cache_address[1:0];

  // Lookup uses the live request in IDLE, the latched request while busy.
  assign w_cmp_index = (r_state == IDLE) ? i_cache_address[INDEX_BITS+1:2]
                                         : r_addr[INDEX_BITS+1:2];
  assign w_cmp_tag   = (r_state == IDLE) ? i_cache_address[ADDR_W-1:INDEX_BITS+2]
                                         : r_addr[ADDR_W-1:INDEX_BITS+2];
  assign w_line_hit  = w_rd_valid && (w_rd_tag == w_cmp_tag);

  data_cache_line_array #(
    .LINES      (LINES),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_lines (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_rd_index (w_cmp_index),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_wr_en),
    .i_wr_index (r_addr[INDEX_BITS+1:2]),
    .i_wr_tag   (r_addr[ADDR_W-1:INDEX_BITS+2]),
    .i_wr_data  (w_wr_data)
  );

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request latches: address on miss or store, data on store only.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_cap_addr) r_addr  <= {i_cache_address[ADDR_W-1:2], 2'b00};
      if (w_cap_data) r_wdata <= io_cache_data;
    end
  end

  // Next-state, hit reporting, line update and memory request decode.
  always_comb begin
    w_next      = r_state;
    o_cache_hit = 1'b0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    w_cap_addr  = 1'b0;
    w_cap_data  = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_data   = r_wdata;
    w_drive     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_cache_write) begin
          w_cap_addr = 1'b1;
          w_cap_data = 1'b1;
          w_next     = WRITE;
        end else if (i_cache_read) begin
          if (w_line_hit) begin
            o_cache_hit = 1'b1;
            w_drive     = 1'b1;
          end else begin
            w_cap_addr = 1'b1;
            w_next     = REFILL;
          end
        end
      end
      REFILL: begin
        o_mem_read = 1'b1;
        if (i_mem_ready) begin
          w_wr_en   = 1'b1;
          w_wr_data = i_mem_data;
          w_next    = IDLE;
        end
      end
      WRITE: begin
        o_mem_write = 1'b1;
        if (i_mem_ready) begin
          o_cache_hit = 1'b1;
          w_wr_en     = w_line_hit;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_mem_address    = r_addr;
  assign o_mem_write_data = r_wdata;
  assign io_cache_data    = w_drive ? w_rd_data : {DATA_W{1'bz}};

endmodule

// File: tb/tb_data_cache.sv
// Randomized self-checking bench for data_cache against a transaction-level model.
module tb_data_cache;

  localparam int unsigned LINES = 16;
  localparam int unsigned IB    = $clog2(LINES);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] r_addr;
  logic        r_rd;
  logic        r_wr;
  logic [31:0] r_drv;
  logic        r_drv_en;
  wire  [31:0] w_bus;
  logic        hit;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] r_mem_data;
  logic        r_mem_ready;

  always #5 clk = ~clk;

  assign w_bus = r_drv_en ? r_drv : {32{1'bz}};

  data_cache #(.LINES(LINES)) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_cache_address  (r_addr),
    .i_cache_read     (r_rd),
    .i_cache_write    (r_wr),
    .io_cache_data    (w_bus),
    .o_cache_hit      (hit),
    .o_mem_address    (mem_addr),
    .o_mem_read       (mem_rd),
    .o_mem_write      (mem_wr),
    .o_mem_write_data (mem_wdata),
    .i_mem_data       (r_mem_data),
    .i_mem_ready      (r_mem_ready)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: cache contents and backing memory.
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  logic [31:0] m_data  [LINES];
  logic [31:0] mem     [bit [31:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a / 4) % LINES;
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (4 * LINES);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [31:0] wa;
    int unsigned ix;
    int unsigned dl;
    wa = a & ~32'h3;
    ix = idx_of(a);
    @(negedge clk);
    r_addr = a; r_rd = 1'b1; r_wr = 1'b0; r_drv_en = 1'b0;
    #1;
    if (m_valid[ix] && m_tag[ix] == tag_of(a)) begin
      check("rd_hit", 32'(hit), 32'd1);
      check("rd_hit_data", w_bus, m_data[ix]);
      check("rd_hit_no_mem", 32'(mem_rd | mem_wr), 32'd0);
    end else begin
      check("rd_miss_hit", 32'(hit), 32'd0);
      @(negedge clk); #1;
      check("refill_mem_read", 32'(mem_rd), 32'd1);
      check("refill_no_write", 32'(mem_wr), 32'd0);
      check("refill_addr", mem_addr, wa);
      check("refill_hit_low", 32'(hit), 32'd0);
      dl = $urandom_range(0, 3);
      repeat (dl) begin
        @(negedge clk); #1;
        check("refill_held", 32'(mem_rd), 32'd1);
        check("refill_addr_held", mem_addr, wa);
      end
      @(negedge clk);
      r_mem_ready = 1'b1; r_mem_data = mem_rd_val(wa);
      #1;
      check("refill_ready_hit_low", 32'(hit), 32'd0);
      @(negedge clk);
      r_mem_ready = 1'b0; r_mem_data = $urandom;
      m_valid[ix] = 1'b1; m_tag[ix] = tag_of(a); m_data[ix] = mem_rd_val(wa);
      #1;
      check("refill_done_hit", 32'(hit), 32'd1);
      check("refill_done_data", w_bus, m_data[ix]);
      check("refill_done_idle", 32'(mem_rd), 32'd0);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic rd_too);
    logic [31:0] wa;
    int unsigned ix;
    int unsigned dl;
    wa = a & ~32'h3;
    ix = idx_of(a);
    @(negedge clk);
    r_addr = a; r_wr = 1'b1; r_rd = rd_too; r_drv = d; r_drv_en = 1'b1;
    #1;
    check("wr_req_hit_low", 32'(hit), 32'd0);
    @(negedge clk); #1;
    check("wr_mem_write", 32'(mem_wr), 32'd1);
    check("wr_no_read", 32'(mem_rd), 32'd0);
    check("wr_addr", mem_addr, wa);
    check("wr_data", mem_wdata, d);
    check("wr_hit_low", 32'(hit), 32'd0);
    dl = $urandom_range(0, 3);
    repeat (dl) begin
      @(negedge clk); #1;
      check("wr_held", 32'(mem_wr), 32'd1);
      check("wr_data_held", mem_wdata, d);
    end
    @(negedge clk);
    r_mem_ready = 1'b1; r_mem_data = $urandom;
    #1;
    check("wr_ack_hit", 32'(hit), 32'd1);
    mem[wa] = d;
    if (m_valid[ix] && m_tag[ix] == tag_of(a)) m_data[ix] = d;
    @(negedge clk);
    r_mem_ready = 1'b0; r_wr = 1'b0; r_rd = 1'b0; r_drv_en = 1'b0;
    #1;
    check("wr_done_idle", 32'(mem_wr), 32'd0);
  endtask

  task automatic idle_ready_pulse();
    @(negedge clk);
    r_rd = 1'b0; r_wr = 1'b0; r_drv_en = 1'b0;
    r_mem_ready = 1'b1; r_mem_data = $urandom;
    @(negedge clk);
    r_mem_ready = 1'b0;
    #1;
    check("idle_ready_no_read", 32'(mem_rd), 32'd0);
    check("idle_ready_no_write", 32'(mem_wr), 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] t;
    logic [31:0] i;
    logic [31:0] o;
    t = 32'($urandom_range(0, 3));
    i = 32'($urandom_range(0, LINES - 1));
    o = 32'($urandom_range(0, 3));
    return (t * 4 * LINES) + (i * 4) + o;
  endfunction

  initial begin
    rst_n = 1'b0; r_addr = '0; r_rd = 1'b0; r_wr = 1'b0;
    r_drv = '0; r_drv_en = 1'b0; r_mem_data = '0; r_mem_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_mem_read", 32'(mem_rd), 32'd0);
    check("rst_mem_write", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed walk through the basic scenarios.
    mem[32'h40] = 32'hDEAD_BEEF;
    do_read(32'h40);
    do_read(32'h40);
    do_read(32'h43);
    do_write(32'h40, 32'h1234_5678, 1'b0);
    do_read(32'h40);
    do_write(32'h80, 32'hCAFE_F00D, 1'b1);
    do_read(32'h80);
    do_read(32'h40);
    idle_ready_pulse();
    do_read(32'h40);

    // Random mix of loads, stores and stray ready pulses.
    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if (op <= 5)      do_read(rand_addr());
      else if (op <= 8) do_write(rand_addr(), $urandom, 1'($urandom_range(0, 1)));
      else              idle_ready_pulse();
    end

    // Reset in the middle of a refill aborts it and empties the cache.
    @(negedge clk);
    r_addr = 32'h1000_0040; r_rd = 1'b1; r_wr = 1'b0;
    @(negedge clk); #1;
    check("abort_refill_started", 32'(mem_rd), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_read", 32'(mem_rd), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_hit", 32'(hit), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1; r_rd = 1'b0;
    do_read(32'h40);
    do_read(32'h40);
    for (int n = 0; n < 40; n++) do_read(rand_addr());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, word-granular L1 data cache sitting directly downstream of the load/store execution unit. It answers the unit's address/read/write requests over the shared bidirectional data bus and reports hits. On misses and stores it runs a blocking handshake to the memory side. Stores are word-wide; sub-word sizing is resolved upstream.

## Interface
Parameters:
- LINES, 16, number of lines; power of two, ≥2; one 32-bit word per line
- INDEX_BITS, $clog2(LINES), index width (derived, not overridden)

Ports:
- i_clock  input  1  sole clock, rising edge
- i_reset_n  input  1  asynchronous, active-low reset
- i_cache_address  input  32  byte address from load/store unit; bits [1:0] ignored
- i_cache_read  input  1  load request, level, held until hit
- i_cache_write  input  1  store request, level
- io_cache_data  inout  32  driven by cache only while returning read data, else Z
- o_cache_hit  output  1  read data valid / store accepted
- o_mem_address  output  32  word-aligned memory address
- o_mem_read  output  1  memory read request
- o_mem_write  output  1  memory write request
- o_mem_write_data  output  32  store data to memory
- i_mem_data  input  32  memory read data, valid with i_mem_ready
- i_mem_ready  input  1  one-cycle completion pulse for current mem request

## Operation
- Address split: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
- Per line: valid bit, tag, 32-bit data. Reset clears all valid bits; tag/data not reset.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, read, write=0: tag match and valid → o_cache_hit=1 combinationally, io_cache_data drives line data. Miss → latch word address, go REFILL.
- IDLE, write=1: latch address and io_cache_data, go WRITE. Write has priority over simultaneous read.
- REFILL: o_mem_read=1, o_mem_address=latched address. On i_mem_ready: write tag/data/valid=1 into line, go IDLE. Line written even if core dropped request.
- WRITE: o_mem_write=1, o_mem_write_data=latched data. On i_mem_ready: if line valid and tag matches, update data (write-update, no allocate on miss); assert o_cache_hit that cycle; go IDLE.
- Outside IDLE, o_cache_hit=0 except WRITE-completion cycle; io_cache_data Z.
- Memory requests held stable from state entry until i_mem_ready; never both read and write.

## Timing
- Reset (async): state IDLE, all valid=0, o_cache_hit=0, o_mem_read=0, o_mem_write=0, o_mem_address=0, o_mem_write_data=0, io_cache_data=Z. Mid-refill/mid-write reset aborts; no line updated.
- Read hit: 0-cycle latency (same cycle as request).
- Read miss: cycle N request → N+1 o_mem_read=1 → i_mem_ready at cycle M → line valid at M+1, hit asserted M+1 if request still held.
- Store: cycle N request → N+1 o_mem_write=1 → o_cache_hit=1 on i_mem_ready cycle M; IDLE from M+1. Store held after M restarts a second write; core must drop it on hit.
- i_mem_ready in IDLE ignored.
- Index aliasing: refill overwrites previous line unconditionally (no dirty state, write-through).

## Structure
- pkg_defines gains cache_state_e {IDLE, REFILL, WRITE} and default LINES constant.
- Sub-module cache_line_array: valid/tag/data storage, async read by index, sync write port, async clear of valid bits.
- Top holds FSM, latches, tri-state driver, memory handshake.

## Test plan
- Reset, read 0x0000_0040 → miss, o_mem_read=1 addr 0x40; ready with 0xDEAD_BEEF → next cycle hit, io_cache_data=0xDEAD_BEEF.
- Re-read 0x40 → hit same cycle, no memory traffic; read 0x43 → same line hit.
- Store 0x1234_5678 to 0x40 (cached) → o_mem_write, data 0x1234_5678; hit on ready; read 0x40 → 0x1234_5678 without refill.
- Store to uncached 0x80 → memory write only; read 0x80 → miss/refill.
- Alias: LINES=16, fill 0x40 then read 0x80 (same index) → refill evicts; read 0x40 misses again.
- Assert i_reset_n=0 during REFILL → o_mem_read drops immediately; after release read 0x40 misses.
